// File: rtl/aes_pkg.sv
// Shared AES definitions for the MixColumns datapath.
// - Width localparams for the 128-bit state, 32-bit columns and bytes.
// - GF(2^8) reduction constant and xtime() (multiply-by-x).
// - Index helpers for the state layout: byte (row r, col c) sits at
//   bit 32c+8r, so row 0 is the least significant byte of a column word.
// - FSM state encoding shared by RTL and bench.
package aes_pkg;
  localparam int STATE_W = 128;
  localparam int COL_W   = 32;
  localparam int BYTE_W  = 8;
  localparam int N_COLS  = 4;
  localparam int N_ROWS  = 4;

  localparam logic [7:0] GF_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Bit offset of column c inside the state.
  function automatic int col_lsb(input int c);
    return COL_W * c;
  endfunction

  // Bit offset of byte (row r, col c) inside the state.
  function automatic int byte_lsb(input int c, input int r);
    return COL_W * c + BYTE_W * r;
  endfunction
endpackage

// File: rtl/mix_single_column.sv
// Combinational mixer for one 32-bit AES column.
// - col_in  : column word, row 0 in bits [7:0]
// - col_out : mixed column word, same layout
// INVERSE=0 applies {02,03,01,01}; INVERSE=1 applies {0e,0b,0d,09}.
// All constants are formed from xtime chains (x2, x4, x8) and XORs.
module mix_single_column
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [7:0] a  [N_ROWS];
  logic [7:0] x2 [N_ROWS];
  logic [7:0] x4 [N_ROWS];
  logic [7:0] x8 [N_ROWS];

  always_comb begin
    col_out = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      a[r]  = col_in[byte_lsb(0, r) +: BYTE_W];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    for (int r = 0; r < N_ROWS; r++) begin
      if (INVERSE) begin
        // e = 8^4^2, b = 8^2^1, d = 8^4^1, 9 = 8^1
        col_out[byte_lsb(0, r) +: BYTE_W] =
            (x8[r] ^ x4[r] ^ x2[r])
          ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
          ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
          ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
      end else begin
        // 3*a = 2*a ^ a
        col_out[byte_lsb(0, r) +: BYTE_W] =
            x2[r]
          ^ (x2[(r+1)%4] ^ a[(r+1)%4])
          ^ a[(r+2)%4]
          ^ a[(r+3)%4];
      end
    end
  end

endmodule

// File: rtl/mix_columns_serial.sv
// Column-serial AES MixColumns / InvMixColumns stage.
// Ports:
// - clk, rst_n          : clock, asynchronous active-low reset
// - in_valid/in_ready   : input handshake for in_state (128-bit)
// - out_valid/out_ready : output handshake for out_state (128-bit)
// - dbg_state           : current FSM state, for observation only
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready; valid, once raised, holds its payload stable until that
// edge. in_ready never depends on in_valid.
// Flow: IDLE accepts a block; BUSY mixes one column per cycle (col 0..3);
// DONE presents the result until accepted. A DONE cycle may accept the next
// block at the same edge, giving one block every 5 cycles.
module mix_columns_serial
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output fsm_state_e         dbg_state
);

  fsm_state_e         state_q, state_d;
  logic [1:0]         col_q;
  logic [STATE_W-1:0] data_q;
  logic [STATE_W-1:0] result_q;
  logic [COL_W-1:0]   col_in;
  logic [COL_W-1:0]   col_out;
  logic               accept;

  assign col_in = data_q[col_lsb(int'(col_q)) +: COL_W];

  mix_single_column #(.INVERSE(INVERSE)) u_mix (
    .col_in  (col_in),
    .col_out (col_out)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (col_q == 2'd3) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? ST_BUSY : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    accept = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      col_q    <= 2'd0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= in_state;
        col_q  <= 2'd0;
      end else if (state_q == ST_BUSY) begin
        result_q[col_lsb(int'(col_q)) +: COL_W] <= col_out;
        col_q <= col_q + 2'd1;  // wraps to 0 after column 3
      end
    end
  end

  // Output comes only from the result register; in_state never reaches it.
  assign out_state = result_q;
  assign dbg_state = state_q;

endmodule
